// File: rtl/pipe_skid_stage.sv
// Pipeline hand-off stage between fetch and decode. With SKID=1 it is a
// two-entry skid buffer whose in_ready comes straight from a flop. With
// SKID=0 it is a single stall register whose in_ready looks through to
// out_ready. A flush clears every held entry, and empty slots read as zero.
`timescale 1ns/1ps
module pipe_skid_stage #(
    parameter int unsigned DW   = 64,
    parameter int unsigned SKID = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          rdy_q;
    logic          in_fire, out_fire;

    // State, payload and registered-ready flops; reset forces an empty, ready stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != TWO);
        end
    end

    // Next-state and payload movement; flush overrides any simultaneous transfer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    // Without a skid slot an accept in ONE always coincides
                    // with a consume, so it can only replace the head entry.
                    if (in_fire && (out_fire || SKID == 0)) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (out_fire) begin
                        main_d  = '0;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Handshake and status outputs
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        occ       = state_q;
        if (SKID != 0) begin
            in_ready = rdy_q;
        end else begin
            in_ready = ~out_valid | out_ready;
        end
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench driving a SKID=1 and a SKID=0 instance with identical
// inputs. Each instance has its own queue of held entries.
`timescale 1ns/1ps
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        ir1, ov1, ir0, ov0;
    logic [63:0] od1, od0;
    logic [1:0]  oc1, oc0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [63:0] q1[$];
    logic [63:0] q0[$];
    logic        rdy1_m = 1'b1;
    logic        rdy0_m = 1'b1;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DW(64), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .occ(oc1)
    );

    pipe_skid_stage #(.DW(64), .SKID(0)) u_stall (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_ready(out_ready), .occ(oc0)
    );

    task automatic chk(input string nm, input logic ov, input logic [63:0] od,
                       input logic [1:0] oc, input logic ir, input int sz,
                       input logic [63:0] hd, input logic er);
        n_cmp++;
        if (ov !== (sz != 0)) begin
            n_bad++;
            $display("FAIL %s out_valid got %0b want %0b @%0t", nm, ov, (sz != 0), $time);
        end
        n_cmp++;
        if (od !== hd) begin
            n_bad++;
            $display("FAIL %s out_data got %h want %h @%0t", nm, od, hd, $time);
        end
        n_cmp++;
        if (oc !== 2'(sz)) begin
            n_bad++;
            $display("FAIL %s occ got %0d want %0d @%0t", nm, oc, sz, $time);
        end
        n_cmp++;
        if (ir !== er) begin
            n_bad++;
            $display("FAIL %s in_ready got %0b want %0b @%0t", nm, ir, er, $time);
        end
    endtask

    // Monitor: compare presented outputs with the queue head, retire on consume
    initial begin
        logic er;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                er = (q1.size() < 2);
                chk("skid1", ov1, od1, oc1, ir1, q1.size(),
                    (q1.size() != 0) ? q1[0] : 64'h0, er);
                rdy1_m = er;
                if (!flush && out_ready && q1.size() != 0) void'(q1.pop_front());

                er = (q0.size() == 0) || out_ready;
                chk("skid0", ov0, od0, oc0, ir0, q0.size(),
                    (q0.size() != 0) ? q0[0] : 64'h0, er);
                rdy0_m = er;
                if (!flush && out_ready && q0.size() != 0) void'(q0.pop_front());
            end
        end
    end

    // One stimulus cycle: drive, then record what each stage must accept
    task automatic cycle(input logic v, input logic [63:0] d, input logic ordy,
                         input logic fl, output logic acc1, output logic acc0);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #3;
        acc1 = v && rdy1_m && !fl;
        acc0 = v && rdy0_m && !fl;
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (acc1) q1.push_back(d);
            if (acc0) q0.push_back(d);
        end
    endtask

    task automatic reset_check(input string nm);
        n_cmp++;
        if (ov1 !== 1'b0 || od1 !== 64'h0 || oc1 !== 2'd0 || ir1 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s skid1 got v=%0b d=%h occ=%0d rdy=%0b want 0/0/0/1",
                     nm, ov1, od1, oc1, ir1);
        end
        n_cmp++;
        if (ov0 !== 1'b0 || od0 !== 64'h0 || oc0 !== 2'd0 || ir0 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s skid0 got v=%0b d=%h occ=%0d rdy=%0b want 0/0/0/1",
                     nm, ov0, od0, oc0, ir0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic a1, a0;
        logic tog;
        logic done;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset_check("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single push, one-cycle latency to out_valid
        cycle(1'b1, 64'h0000_0004_2402_0001, 1'b1, 1'b0, a1, a0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, a1, a0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, a1, a0);

        // Fill while stalled, third offer refused, then drain in order
        cycle(1'b1, 64'h11, 1'b0, 1'b0, a1, a0);
        cycle(1'b1, 64'h22, 1'b0, 1'b0, a1, a0);
        cycle(1'b1, 64'h33, 1'b0, 1'b0, a1, a0);
        repeat (3) cycle(1'b0, 64'h0, 1'b1, 1'b0, a1, a0);

        // Flush while full with simultaneous offer and consume
        cycle(1'b1, 64'hA, 1'b0, 1'b0, a1, a0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0, a1, a0);
        cycle(1'b1, 64'hC, 1'b1, 1'b1, a1, a0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, a1, a0);

        // Stream 1..8 into the stall register with out_ready toggling
        tog = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
                cycle(1'b1, 64'(k), tog, 1'b0, a1, a0);
                tog  = ~tog;
                done = a0;
            end
            n_cmp++;
            if (!done) begin
                n_bad++;
                $display("FAIL stream value %0d not accepted got 0 want 1", k);
            end
        end
        repeat (4) cycle(1'b0, 64'h0, 1'b1, 1'b0, a1, a0);

        // Asynchronous reset between edges while holding one entry
        cycle(1'b1, 64'h55, 1'b0, 1'b0, a1, a0);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, a1, a0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 reset_check("async_reset");
        q1.delete();
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 64'h66, 1'b1, 1'b0, a1, a0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, a1, a0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, a1, a0);

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0,
                  ($urandom % 50) == 0, a1, a0);
        end
        repeat (4) cycle(1'b0, 64'h0, 1'b1, 1'b0, a1, a0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DW, default 64, payload width in bits (legal range 1..256).
REQ-002 SHALL have parameter SKID, default 1; 1 = two-entry skid stage with registered in_ready, 0 = single-entry stall register.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous clear of all held entries (branch/exception kill).
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_data  input  DW  upstream payload, e.g. {pc_4, instr}.
REQ-008 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a live entry.
REQ-010 SHALL have port out_data  output  DW  head-entry payload.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head this cycle.
REQ-012 SHALL have port occ  output  2  entries held: 0, 1 or 2.

Function
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 SHALL hold entries in a main register (drives out_data) and, when SKID=1, a skid register; out_valid SHALL equal (occ != 0).
REQ-015 SHALL, with SKID=1, implement states EMPTY (occ 0), ONE (occ 1), TWO (occ 2), and in_ready SHALL be a register output equal to (state != TWO), with no combinational path from out_ready.
REQ-016 SHALL, in EMPTY, on in_fire load main <= in_data and go to ONE; otherwise stay.
REQ-017 SHALL, in ONE: in_fire & out_fire -> main <= in_data, stay ONE; in_fire only -> skid <= in_data, go TWO; out_fire only -> EMPTY; neither -> hold.
REQ-018 SHALL, in TWO, ignore in_valid; on out_fire main <= skid, skid <= 0, go ONE; otherwise hold both.
REQ-019 SHALL, with SKID=0, drive in_ready = ~out_valid | out_ready combinationally; in_fire loads main (occ 1); out_fire without in_fire -> occ 0; occ never 2.
REQ-020 SHALL deliver each accepted payload unmodified and in acceptance order; latency in_fire -> out_valid is exactly 1 cycle when the stage is empty.
REQ-021 SHALL never drop or duplicate an entry: every in_fire is matched by exactly one later out_fire unless removed by flush or rst.
REQ-022 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on flush=1 at a rising edge, set occ to 0, main and skid to all-zero, and discard any simultaneous in_fire/out_fire, regardless of state.
REQ-024 SHALL, when flush=1, still report in_ready per REQ-015/REQ-019; the entry offered that cycle is discarded, not stored.
REQ-025 SHALL drive out_data = all-zero whenever occ = 0 (bubble = NOP for the decode stage).

Reset
REQ-026 SHALL, while rst=1, asynchronously force occ=0, out_valid=0, out_data=0, skid=0, and in_ready=1 (SKID=1) or in_ready=1 via REQ-019 (SKID=0).
REQ-027 SHALL abandon any in-progress entry on reset assertion mid-operation and resume from EMPTY on the first rising edge after rst falls.

Verification
REQ-028 SHALL pass: SKID=1, DW=64, in_valid=1 with 0x0000_0004_2402_0001 one cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x0000_0004_2402_0001, occ=1.
REQ-029 SHALL pass: SKID=1, out_ready=0, push A=0x11, B=0x22 on consecutive cycles -> occ=2, in_ready=0 next cycle; third offer C=0x33 not accepted; out_ready=1 -> outputs A then B, in_ready returns to 1 the cycle after A leaves.
REQ-030 SHALL pass: SKID=1, occ=2, flush=1 with in_valid=1 and out_ready=1 same cycle -> next cycle occ=0, out_valid=0, out_data=0, nothing emitted.
REQ-031 SHALL pass: SKID=0, stream 0x1..0x8 with out_ready toggling 1,0,1,0 -> output sequence 0x1..0x8 exact, in_ready low exactly when out_valid=1 and out_ready=0.
REQ-032 SHALL pass: rst pulsed asynchronously between clock edges while occ=1 -> out_valid=0, out_data=0 before the next edge; first push after release returns 1-cycle latency.
REQ-033 SHALL pass: random in_valid/out_ready/flush (10k cycles, both SKID values) -> scoreboard order match, occ always in {0,1,2}, no payload loss outside flush/rst.
